// File: rtl/keychain_pkg.sv
// Shared definitions for the RSA decoder: default word width and the
// controller state encoding.
package keychain_pkg;

  localparam int WORD_W = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SQUARE = 2'd1,
    MULT   = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage : keychain_pkg

// File: rtl/rsa_decoder_mod_mult.sv
// mod_mult: interleaved (MSB-first) shift-add-reduce modular multiplier.
// p = a*b mod m, valid when done pulses. The start cycle performs the first
// iteration, WIDTH-1 further iterations follow, and done is raised for one
// cycle afterwards: WIDTH+1 cycles from start to the cycle done is seen,
// regardless of operand values. Requires b < m.
module mod_mult
  import keychain_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  // One iteration: r' = (2r + bit*b) mod m. With r < m and b < m the sum is
  // below 3m, so two conditional subtractions keep the residue below m.
  function automatic logic [WIDTH-1:0] mm_step(
    input logic [WIDTH-1:0] r,
    input logic             abit,
    input logic [WIDTH-1:0] bv,
    input logic [WIDTH-1:0] mv
  );
    logic [WIDTH+1:0] t;
    t = {1'b0, r, 1'b0} + (abit ? {2'b00, bv} : {(WIDTH+2){1'b0}});
    if (t >= {2'b00, mv}) begin
      t = t - {2'b00, mv};
    end else begin
      t = t;
    end
    if (t >= {2'b00, mv}) begin
      t = t - {2'b00, mv};
    end else begin
      t = t;
    end
    return t[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0] a_d, a_q;
  logic [WIDTH-1:0] b_d, b_q;
  logic [WIDTH-1:0] m_d, m_q;
  logic [WIDTH-1:0] r_d, r_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;

  // Next-state: load and first iteration on start, then iterate until the count expires.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    m_d    = m_q;
    r_d    = r_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start && !busy_q) begin
      r_d    = mm_step({WIDTH{1'b0}}, a[WIDTH-1], b, m);
      a_d    = {a[WIDTH-2:0], 1'b0};
      b_d    = b;
      m_d    = m;
      cnt_d  = CNT_W'(WIDTH - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      r_d   = mm_step(r_q, a_q[WIDTH-1], b_q, m_q);
      a_d   = {a_q[WIDTH-2:0], 1'b0};
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Multiplier state registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      a_q    <= {WIDTH{1'b0}};
      b_q    <= {WIDTH{1'b0}};
      m_q    <= {WIDTH{1'b0}};
      r_q    <= {WIDTH{1'b0}};
      cnt_q  <= {CNT_W{1'b0}};
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      m_q    <= m_d;
      r_q    <= r_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign p    = r_q;

endmodule : mod_mult

// File: rtl/rsa_decoder.sv
// rsa_decoder: computes line_out = cipher_in^private_key mod modulus with a
// constant-time left-to-right square-and-multiply over all WIDTH key bits,
// using one shared mod_mult.
// Optional feature: define RSA_DECODER_RANGE_CHECK_EN to reject
// cipher_in >= modulus or modulus < 2 at accept (err_out=1, line_out=0).
module rsa_decoder
  import keychain_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] cipher_in,
  input  logic [WIDTH-1:0] private_key,
  input  logic [WIDTH-1:0] modulus,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] line_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_out
);

  localparam int IDX_W = $clog2(WIDTH);

  state_e           state_d, state_q;
  logic [WIDTH-1:0] base_d, base_q;
  logic [WIDTH-1:0] key_d, key_q;
  logic [WIDTH-1:0] mod_d, mod_q;
  logic [WIDTH-1:0] acc_d, acc_q;
  logic [IDX_W-1:0] idx_d, idx_q;
  logic             start_d, start_q;
  logic             in_ready_d, in_ready_q;
  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] line_out_d, line_out_q;
`ifdef RSA_DECODER_RANGE_CHECK_EN
  logic             err_d, err_q;
`endif

  logic [WIDTH-1:0] mult_b_s;
  logic [WIDTH-1:0] mult_p_s;
  logic             mult_done_s;

  // Squaring uses acc for both operands; the multiply step uses the captured base.
  always_comb begin
    if (state_q == MULT) begin
      mult_b_s = base_q;
    end else begin
      mult_b_s = acc_q;
    end
  end

  mod_mult #(.WIDTH(WIDTH)) u_mod_mult (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .start  (start_q),
    .a      (acc_q),
    .b      (mult_b_s),
    .m      (mod_q),
    .done   (mult_done_s),
    .p      (mult_p_s)
  );

  // Controller next-state: accept, alternate square/multiply per key bit, present result.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    key_d       = key_q;
    mod_d       = mod_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    start_d     = 1'b0;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    line_out_d  = line_out_q;
`ifdef RSA_DECODER_RANGE_CHECK_EN
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          base_d     = cipher_in;
          key_d      = private_key;
          mod_d      = modulus;
          acc_d      = {{(WIDTH-1){1'b0}}, 1'b1};
          idx_d      = IDX_W'(WIDTH - 1);
          in_ready_d = 1'b0;
`ifdef RSA_DECODER_RANGE_CHECK_EN
          if ((cipher_in >= modulus) || (modulus < WIDTH'(2))) begin
            state_d     = DONE;
            line_out_d  = {WIDTH{1'b0}};
            err_d       = 1'b1;
            out_valid_d = 1'b1;
          end else begin
            state_d = SQUARE;
            start_d = 1'b1;
          end
`else
          state_d = SQUARE;
          start_d = 1'b1;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SQUARE: begin
        if (mult_done_s) begin
          acc_d   = mult_p_s;
          state_d = MULT;
          start_d = 1'b1;
        end else begin
          state_d = SQUARE;
        end
      end
      MULT: begin
        if (mult_done_s) begin
          // Product is always computed; only the commit depends on the key bit.
          if (key_q[idx_q]) begin
            acc_d = mult_p_s;
          end else begin
            acc_d = acc_q;
          end
          if (idx_q == IDX_W'(0)) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = SQUARE;
            start_d = 1'b1;
          end
        end else begin
          state_d = MULT;
        end
      end
      DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          line_out_d  = acc_q;
`ifdef RSA_DECODER_RANGE_CHECK_EN
          err_d       = 1'b0;
`endif
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Controller registers; reset aborts any operation in flight.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      base_q      <= {WIDTH{1'b0}};
      key_q       <= {WIDTH{1'b0}};
      mod_q       <= {WIDTH{1'b0}};
      acc_q       <= {WIDTH{1'b0}};
      idx_q       <= {IDX_W{1'b0}};
      start_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      line_out_q  <= {WIDTH{1'b0}};
`ifdef RSA_DECODER_RANGE_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      key_q       <= key_d;
      mod_q       <= mod_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      start_q     <= start_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      line_out_q  <= line_out_d;
`ifdef RSA_DECODER_RANGE_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign line_out  = line_out_q;
`ifdef RSA_DECODER_RANGE_CHECK_EN
  assign err_out   = err_q;
`else
  assign err_out   = 1'b0;
`endif

endmodule : rsa_decoder
